// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the queue entry layout and the decode-facing packing helper.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [DEF_INSTR_W+DEF_ADDR_W-1:0] pack_if_out(
        input fetch_entry_t e
    );
        return {e.instr, e.pc};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries.
// Flush empties the queue and wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           din,
    output entry_t           dout,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: PC sequencing, one in-flight imem read, prefetch queue.
// Credit counts the in-flight read so a return always has a free slot.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = 4,
    parameter int PC_INC  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    input  logic                       br_valid,
    input  logic [ADDR_W-1:0]          br_target,
    output logic                       imem_rd_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [INSTR_W+ADDR_W-1:0]  if_out,
    output logic [$clog2(DEPTH+1)-1:0] if_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic              pending;
    logic [ADDR_W-1:0] pending_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    used;
    logic              credit;
    logic              issue;
    logic              push;
    logic              pop;
    entry_t            din;
    entry_t            head;

    assign used   = {1'b0, count} + {{CNT_W{1'b0}}, pending};
    assign credit = used < (CNT_W + 1)'(DEPTH);
    assign issue  = rst_n & fetch_en & ~br_valid & credit;

    assign push     = pending & ~br_valid;
    assign if_valid = (count != '0) & ~br_valid;
    assign pop      = if_valid & if_ready;

    assign din.instr = imem_rdata;
    assign din.pc    = pending_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else if (br_valid) begin
            fetch_pc <= br_target;
            pending  <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + ADDR_W'(PC_INC);
            end
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (br_valid),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc;
    assign if_out     = {head.instr, head.pc};
    assign if_count   = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a registered-read imem model.
// Per-cycle vector table plus hand sequences for wrap and async reset.
module tb_fetch_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        br_valid;
    logic [7:0]  br_target;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [23:0] if_out;
    logic [2:0]  if_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       fe;
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        logic       e_rd;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_pc;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    fetch_prefetch_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_out     (if_out),
        .if_count   (if_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 16'h1000 + {8'h00, imem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fe, input logic rdy, input logic br,
                       input logic [7:0] tgt, input logic e_rd,
                       input logic [7:0] e_addr, input logic e_valid,
                       input logic [7:0] e_pc, input logic [2:0] e_cnt);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic br,
                         input logic [7:0] tgt);
        @(negedge clk);
        fetch_en  = fe;
        if_ready  = rdy;
        br_valid  = br;
        br_target = tgt;
        #1;
    endtask

    initial begin
        logic [7:0]  pcs [3];
        int          cyc [3];
        int          n;
        logic [15:0] e_instr;

        rst_n = 1'b0;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        br_valid = 1'b0;
        br_target = 8'h00;
        imem_rdata = 16'h0;

        // Reset release, streaming, 10-cycle stall, redirect, fetch_en gap.
        add(1,1,0,8'h00, 1,8'h00, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h01, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h02, 1,8'h00, 1);
        add(1,1,0,8'h00, 1,8'h03, 1,8'h01, 1);
        add(1,1,0,8'h00, 1,8'h04, 1,8'h02, 1);
        add(1,0,0,8'h00, 1,8'h05, 1,8'h03, 1);
        add(1,0,0,8'h00, 1,8'h06, 1,8'h03, 2);
        add(1,0,0,8'h00, 0,8'h07, 1,8'h03, 3);
        for (int i = 0; i < 7; i++)
            add(1,0,0,8'h00, 0,8'h07, 1,8'h03, 4);
        add(1,1,0,8'h00, 0,8'h07, 1,8'h03, 4);
        add(1,1,0,8'h00, 1,8'h07, 1,8'h04, 3);
        add(1,1,0,8'h00, 1,8'h08, 1,8'h05, 2);
        add(1,1,0,8'h00, 1,8'h09, 1,8'h06, 2);
        add(1,1,0,8'h00, 1,8'h0A, 1,8'h07, 2);
        add(1,0,0,8'h00, 1,8'h0B, 1,8'h08, 2);
        add(1,1,1,8'h40, 0,8'h0C, 0,8'h00, 3);
        add(1,1,0,8'h00, 1,8'h40, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h41, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h42, 1,8'h40, 1);
        add(1,1,0,8'h00, 1,8'h43, 1,8'h41, 1);
        add(0,1,0,8'h00, 0,8'h44, 1,8'h42, 1);
        add(0,1,0,8'h00, 0,8'h44, 1,8'h43, 1);
        for (int i = 0; i < 3; i++)
            add(0,1,0,8'h00, 0,8'h44, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h44, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h45, 0,8'h00, 0);
        add(1,1,0,8'h00, 1,8'h46, 1,8'h44, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_count", 32'(if_count), 32'd0);
        chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h00);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n     = 1'b1;
            fetch_en  = vq[i].fe;
            if_ready  = vq[i].rdy;
            br_valid  = vq[i].br;
            br_target = vq[i].tgt;
            #1;
            chk($sformatf("c%0d_rd_en", i), 32'(imem_rd_en), 32'(vq[i].e_rd));
            chk($sformatf("c%0d_addr", i), 32'(imem_addr), 32'(vq[i].e_addr));
            chk($sformatf("c%0d_valid", i), 32'(if_valid), 32'(vq[i].e_valid));
            chk($sformatf("c%0d_count", i), 32'(if_count), 32'(vq[i].e_cnt));
            if (vq[i].e_valid) begin
                e_instr = 16'h1000 + {8'h00, vq[i].e_pc};
                chk($sformatf("c%0d_pc", i), 32'(if_out[7:0]),
                    32'(vq[i].e_pc));
                chk($sformatf("c%0d_instr", i), 32'(if_out[23:8]),
                    32'(e_instr));
            end
        end

        // PC wrap: redirect to 0xFE, expect FE, FF, 00 on consecutive cycles.
        drive(1, 1, 1, 8'hFE);
        chk("wrap_br_valid", 32'(if_valid), 32'd0);
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            drive(1, 1, 0, 8'h00);
            if (if_valid && if_ready) begin
                pcs[n] = if_out[7:0];
                cyc[n] = k;
                chk($sformatf("wrap_instr%0d", n), 32'(if_out[23:8]),
                    32'(16'h1000 + {8'h00, if_out[7:0]}));
                n++;
            end
        end
        chk("wrap_seen", 32'(n), 32'd3);
        if (n == 3) begin
            chk("wrap_first_cyc", 32'(cyc[0]), 32'd2);
            chk("wrap_pc0", 32'(pcs[0]), 32'hFE);
            chk("wrap_pc1", 32'(pcs[1]), 32'hFF);
            chk("wrap_pc2", 32'(pcs[2]), 32'h00);
            chk("wrap_gap", 32'(cyc[2] - cyc[0]), 32'd2);
        end

        // Async reset while idle-streaming.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(if_count), 32'd0);
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'h00);

        // Build count=2 with a read in flight, then pulse reset mid-cycle.
        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b0;
        fetch_en = 1'b1;
        #1;
        chk("r2_c0_rd_en", 32'(imem_rd_en), 32'd1);
        drive(1, 0, 0, 8'h00);
        drive(1, 0, 0, 8'h00);
        chk("r2_c2_count", 32'(if_count), 32'd1);
        drive(1, 0, 0, 8'h00);
        chk("r2_c3_count", 32'(if_count), 32'd2);
        chk("r2_c3_rd_en", 32'(imem_rd_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r2_pulse_count", 32'(if_count), 32'd0);
        chk("r2_pulse_valid", 32'(if_valid), 32'd0);
        chk("r2_pulse_addr", 32'(imem_addr), 32'h00);

        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b1;
        #1;
        chk("r3_c0_addr", 32'(imem_addr), 32'h00);
        chk("r3_c0_valid", 32'(if_valid), 32'd0);
        drive(1, 1, 0, 8'h00);
        chk("r3_c1_valid", 32'(if_valid), 32'd0);
        drive(1, 1, 0, 8'h00);
        chk("r3_c2_valid", 32'(if_valid), 32'd1);
        chk("r3_c2_pc", 32'(if_out[7:0]), 32'h00);
        chk("r3_c2_instr", 32'(if_out[23:8]), 32'h1000);
        drive(1, 1, 0, 8'h00);
        chk("r3_c3_pc", 32'(if_out[7:0]), 32'h01);
        chk("r3_c3_instr", 32'(if_out[23:8]), 32'h1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
